// File: rtl/seq_wide_adder_pkg.sv
// rtl/seq_wide_adder_pkg.sv - shared constants, state encoding and slice helper for seq_wide_adder
package seq_wide_adder_pkg;

    localparam int SLICE_W   = 16;
    localparam int MAX_WORDS = 64;
    localparam int WIDE_W    = SLICE_W * MAX_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Callers zero-extend their operand to WIDE_W; unused upper bits are constant and trim away.
    function automatic logic [SLICE_W-1:0] slice_of(input logic [WIDE_W-1:0] v, input int unsigned k);
        return v[k*SLICE_W +: SLICE_W];
    endfunction

endpackage

// File: rtl/seq_wide_adder_cla16.sv
// rtl/seq_wide_adder_cla16.sv - 16-bit group-lookahead slice adder with group generate/propagate
module seq_wide_adder_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        g_16,
    output logic        p_16
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [3:0]  cg;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end

        cg[0] = c_in;
        cg[1] = gg[0] | (pg[0] & c_in);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c_in);

        // Group carries come from lookahead; only the 3 bits inside each group ripple.
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = cg[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end

        s    = p ^ c;
        g_16 = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
        p_16 = &pg;
    end

endmodule

// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle wide adder streaming 16-bit slices through one lookahead slice adder
module seq_wide_adder
    import seq_wide_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                   c_in,
    output logic                   ready,
    output logic                   done,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                   c_out
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t             state;
    state_t             state_nx;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [IDX_W-1:0]   idx;
    logic               cy;

    logic [WIDE_W-1:0]  a_ext;
    logic [WIDE_W-1:0]  b_ext;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               g_16;
    logic               p_16;
    logic               cy_nx;

    assign a_ext   = WIDE_W'(a_r);
    assign b_ext   = WIDE_W'(b_r);
    assign slice_a = slice_of(a_ext, 32'(idx));
    assign slice_b = slice_of(b_ext, 32'(idx));

    seq_wide_adder_cla16 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .c_in (cy),
        .s    (slice_s),
        .g_16 (g_16),
        .p_16 (p_16)
    );

    // Next-slice carry uses only the group signals, keeping the path to one slice plus this merge.
    assign cy_nx = g_16 | (p_16 & cy);

    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (idx == LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            cy    <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        cy  <= c_in;
                        idx <= '0;
                    end
                end
                ST_RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= slice_s;
                    cy <= cy_nx;
                    if (idx == LAST) begin
                        c_out <= cy_nx;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_wide_adder.sv
// tb/tb_seq_wide_adder.sv - self-checking bench for seq_wide_adder
module tb_seq_wide_adder;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[5];

    seq_wide_adder #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a = ta;
        b = tb_v;
        c_in = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta;
        b = ~tb_v;
        c_in = ~tc;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 50);
        rs = sum;
        rc = c_out;
    endtask

    logic [W-1:0] r_sum;
    logic         r_cout;
    int           r_lat;
    logic [W:0]   ref_v;
    int           pulses;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    int           issued;
    int           completed;
    int           last_acc;
    int           cyc;

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        vecs[1] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};
        vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1};
        vecs[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_ready", W'(ready), W'(1));
        check("reset_done", W'(done), W'(0));
        check("reset_sum", sum, '0);
        check("reset_cout", W'(c_out), W'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, r_sum, r_cout, r_lat);
            check($sformatf("vec%0d_latency", i), W'(r_lat), W'(5));
            check($sformatf("vec%0d_sum", i), r_sum, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), W'(r_cout), W'(vecs[i].exp_cout));
            @(negedge clk);
            check($sformatf("vec%0d_done_once", i), W'(done), W'(0));
            check($sformatf("vec%0d_ready_after", i), W'(ready), W'(1));
            check($sformatf("vec%0d_sum_held", i), sum, vecs[i].exp_sum);
        end

        // start held through RUN and DONE with different operands must be ignored
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'h1111_1111_1111_1111;
        c_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_DEAD_BEEF;
        b = 64'h7777_7777_7777_7777;
        c_in = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("ignore_sum", sum, 64'h1234_5678_9ABC_DF00);
                check("ignore_cout", W'(c_out), W'(0));
            end
        end
        start = 1'b0;
        check("ignore_ready", W'(ready), W'(1));
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_one_pulse", W'(pulses), W'(1));

        // reset during the second RUN cycle
        a = 64'h1234;
        b = 64'h1;
        c_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sum", sum, '0);
        check("abort_cout", W'(c_out), W'(0));
        check("abort_ready", W'(ready), W'(1));
        check("abort_done", W'(done), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", W'(pulses), W'(0));
        run_op(64'd3, 64'd4, 1'b1, r_sum, r_cout, r_lat);
        check("post_reset_sum", r_sum, 64'd8);
        check("post_reset_cout", W'(r_cout), W'(0));
        check("post_reset_latency", W'(r_lat), W'(5));

        // back-to-back with start held high
        issued = 0;
        completed = 0;
        last_acc = -1;
        cyc = 0;
        @(negedge clk);
        while (completed < 200 && cyc < 3000) begin
            if (done) begin
                ref_v = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()} + {{W{1'b0}}, qc.pop_front()};
                check($sformatf("b2b_sum%0d", completed), sum, ref_v[W-1:0]);
                check($sformatf("b2b_cout%0d", completed), W'(c_out), W'(ref_v[W]));
                completed++;
            end
            if (ready) begin
                if (issued < 200) begin
                    if (last_acc >= 0) check("b2b_period", W'(cyc - last_acc), W'(6));
                    last_acc = cyc;
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    c_in = 1'($urandom_range(0, 1));
                    qa.push_back(a);
                    qb.push_back(b);
                    qc.push_back(c_in);
                    start = 1'b1;
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b_completed", W'(completed), W'(200));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_wide_adder.md
# seq_wide_adder

Multi-cycle wide adder that streams a 16·WORDS-bit addition through a single 16-bit group-lookahead slice adder, one 16-bit slice per clock, least-significant slice first. It sits directly upstream of the 16-bit lookahead adder. It feeds the adder one operand slice and a registered carry-in each cycle. It consumes the adder's slice sum and group generate/propagate signals, and turns them into the next slice's carry. The result is a wide sum, a carry-out and a done handshake.

## Interface
Parameters:
- WORDS, default 4, number of 16-bit slices; legal range ≥ 2 (default gives a 64-bit adder).

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- start  input  1  request; sampled only while ready=1.
- a  input  16·WORDS  operand A; captured when start is accepted.
- b  input  16·WORDS  operand B; captured when start is accepted.
- c_in  input  1  carry into slice 0; captured when start is accepted.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; sum/c_out valid.
- sum  output  16·WORDS  registered result; held until the next accepted start.
- c_out  output  1  carry out of the top slice; held with sum.

## Operation
- States are IDLE, RUN and DONE, held in a 2-bit encoding.
- IDLE:
  - ready=1.
  - start=1 at an edge latches a, b and c_in.
  - Also at that edge: slice index idx←0, carry register cy←c_in, state←RUN.
- RUN:
  - The slice adder receives a_r[16·idx+15:16·idx], b_r[same slice] and cy.
  - At each edge, sum[slice idx] ← slice sum and cy ← g_16 | (p_16 & cy).
  - At the edge where idx=WORDS-1: state←DONE. Otherwise idx←idx+1.
- DONE:
  - done=1 and c_out=cy, for one cycle.
  - Next edge returns unconditionally to IDLE.
- start while ready=0 (RUN or DONE) is ignored, not queued.
- Operands are latched: changes on a/b/c_in after acceptance do not affect the result.
- Width and arithmetic:
  - idx is $clog2(WORDS) bits; it never exceeds WORDS-1.
  - Addition is unsigned modulo 2^(16·WORDS); the overflow bit is c_out only.
  - Slice carry is taken only from g_16/p_16, never from a ripple path.
- sum is written only in RUN. Slices not yet written in the current operation keep their previous value until overwritten; they are guaranteed valid only at done.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - state=IDLE, ready=1, done=0, sum=0, c_out=0, idx=0, cy=0, operand registers=0.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+WORDS. That is WORDS+1 cycles from acceptance (5 cycles for WORDS=4).
- Throughput: one operation per WORDS+2 cycles. ready rises the cycle after done, and start may be accepted at that cycle's edge.
- Reset asserted mid-RUN or in DONE aborts the operation:
  - done never pulses.
  - All outputs take their reset values immediately.
- c_out is updated only on entry to DONE, and is stable from done until the next acceptance.
- Critical path per cycle is one slice adder plus the carry merge (g_16 | p_16&cy). No wide carry chain is allowed.

## Structure
- Shared package:
  - SLICE_W=16.
  - State encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Function to extract slice k of a 16·WORDS vector.
- One sub-module instance: the team's existing 16-bit group-lookahead slice adder, driven from the slice muxes. Its group g/p outputs are used; its internal carries are not.
- The wrapper contains:
  - the FSM;
  - idx counter and cy register;
  - operand registers;
  - slice mux for operands and demux-write for sum.

## Test plan
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0 → sum=0, c_out=1, done exactly 5 cycles after acceptance.
- a=0x0000_FFFF_0000_FFFF, b=0x0000_0001_0000_0001, c_in=0 → sum=0x0001_0000_0001_0000, c_out=0 (carries cross slices 0→1 and 2→3).
- All-propagate chain: a=0xAAAA_AAAA_AAAA_AAAA, b=0x5555_5555_5555_5555, c_in=1 → sum=0, c_out=1; with c_in=0 → sum=0xFFFF_FFFF_FFFF_FFFF, c_out=0.
- start pulsed during RUN and during DONE, with different operands → ignored; result matches the first operands; exactly one done pulse.
- rst_n low for 1 cycle during the second RUN cycle → sum=0, c_out=0, ready=1 immediately, no done. Then a=3, b=4, c_in=1 → sum=8.
- Back-to-back: start held high continuously with 200 random operand pairs → each accepted on the first ready cycle, one operation per 6 cycles; every sum/c_out matches the reference model.
